// File: rtl/puf_pkg.sv
// Shared types and default constants for the PUF ring-oscillator datapath.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        DONE
    } meter_state_t;

    localparam int DEF_CW         = 16;
    localparam int DEF_SETTLE_CYC = 1000;
    localparam int DEF_GATE_CYC   = 100000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous oscillator output, plus a third
// register that turns the synchronized level into a one-cycle rising-edge pulse.
module edge_sync (
    input  logic CLK,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge CLK) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/ro_pair_meter.sv
// Ring-oscillator pair meter: enables both oscillators, lets them settle, counts
// synchronized rising edges over a fixed gate window and reports the comparison.
module ro_pair_meter
    import puf_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int GATE_CYC   = DEF_GATE_CYC
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          start,
    input  logic          ro_a,
    input  logic          ro_b,
    output logic          ro_en,
    output logic          busy,
    output logic          valid,
    output logic [CW-1:0] count_a,
    output logic [CW-1:0] count_b,
    output logic          resp,
    output logic          tie,
    output logic          sat
);

    localparam int              TW          = $clog2(max_int(SETTLE_CYC, GATE_CYC) + 1);
    localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]   GATE_LOAD   = TW'(GATE_CYC - 1);
    localparam logic [CW-1:0]   CNT_MAX     = '1;

    meter_state_t  state_q;
    meter_state_t  state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [CW-1:0] cnt_a_q;
    logic [CW-1:0] cnt_a_d;
    logic [CW-1:0] cnt_b_q;
    logic [CW-1:0] cnt_b_d;
    logic          sat_q;
    logic          sat_d;
    logic          rise_a;
    logic          rise_b;
    logic          gate_last;

    edge_sync u_sync_a (
        .CLK  (CLK),
        .rst  (rst),
        .d    (ro_a),
        .rise (rise_a)
    );

    edge_sync u_sync_b (
        .CLK  (CLK),
        .rst  (rst),
        .d    (ro_b),
        .rise (rise_b)
    );

    // One down-counter serves both SETTLE and GATE; it is reloaded on entry to each.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        gate_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    timer_d = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = GATE;
                    timer_d = GATE_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GATE: begin
                if (timer_q == '0) begin
                    state_d   = DONE;
                    gate_last = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating edge counters; the flag marks any channel that reached full scale.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        sat_d   = sat_q;
        if (state_q == IDLE && start) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
            sat_d   = 1'b0;
        end else if (state_q == GATE) begin
            if (rise_a && cnt_a_q != CNT_MAX) begin
                cnt_a_d = cnt_a_q + CW'(1);
            end
            if (rise_b && cnt_b_q != CNT_MAX) begin
                cnt_b_d = cnt_b_q + CW'(1);
            end
            if (cnt_a_d == CNT_MAX || cnt_b_d == CNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            sat_q   <= sat_d;
        end
    end

    // Results are captured on the edge that enters DONE, including the final gate cycle.
    always_ff @(posedge CLK) begin
        if (rst) begin
            valid   <= 1'b0;
            count_a <= '0;
            count_b <= '0;
            resp    <= 1'b0;
            tie     <= 1'b0;
            sat     <= 1'b0;
        end else begin
            valid <= gate_last;
            if (gate_last) begin
                count_a <= cnt_a_d;
                count_b <= cnt_b_d;
                resp    <= (cnt_a_d > cnt_b_d);
                tie     <= (cnt_a_d == cnt_b_d);
                sat     <= sat_d;
            end
        end
    end

    assign ro_en = (state_q == SETTLE) || (state_q == GATE);
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ro_pair_meter.sv
// Bench for ro_pair_meter: two instances (CW=8 and CW=4) share stimulus and are
// checked every cycle against an edge-history model plus literal expectations.
module tb_ro_pair_meter;

    localparam int S     = 4;
    localparam int G     = 100;
    localparam int HLEN  = 8192;

    logic       CLK = 1'b0;
    logic       rst;
    logic       start;
    logic       ro_a;
    logic       ro_b;

    logic       ro_en8, busy8, valid8, resp8, tie8, sat8;
    logic [7:0] count_a8, count_b8;
    logic       ro_en4, busy4, valid4, resp4, tie4, sat4;
    logic [3:0] count_a4, count_b4;

    int vectors     = 0;
    int miscompares = 0;
    int fail_prints = 0;
    bit chk_en      = 1'b0;

    int gen_mode    = 1;
    int per_a       = 10;
    int per_b       = 8;
    int ph_a        = 0;
    int ph_b        = 0;
    int since_start = 1000;
    bit lvl         = 1'b0;

    bit xa [0:HLEN-1];
    bit xb [0:HLEN-1];
    int n      = 0;
    int t      = 0;
    bit active = 1'b0;

    logic       m_valid, m_busy, m_ro_en;
    logic [7:0] m_a8, m_b8;
    logic [3:0] m_a4, m_b4;
    logic       m_resp8, m_tie8, m_sat8, m_resp4, m_tie4, m_sat4;

    always #5 CLK = ~CLK;

    ro_pair_meter #(.CW(8), .SETTLE_CYC(S), .GATE_CYC(G)) dut8 (
        .CLK(CLK), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .ro_en(ro_en8), .busy(busy8), .valid(valid8),
        .count_a(count_a8), .count_b(count_b8),
        .resp(resp8), .tie(tie8), .sat(sat8)
    );

    ro_pair_meter #(.CW(4), .SETTLE_CYC(S), .GATE_CYC(G)) dut4 (
        .CLK(CLK), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .ro_en(ro_en4), .busy(busy4), .valid(valid4),
        .count_a(count_a4), .count_b(count_b4),
        .resp(resp4), .tie(tie4), .sat(sat4)
    );

    // Oscillator sources change shortly after each rising edge, well away from sampling.
    always @(posedge CLK) begin
        #2;
        ph_a        = ph_a + 1;
        ph_b        = ph_b + 1;
        since_start = since_start + 1;
        case (gen_mode)
            0: begin
                ro_a = ((ph_a % per_a) < (per_a / 2));
                ro_b = ((ph_b % per_b) < (per_b / 2));
            end
            1: begin
                ro_a = lvl;
                ro_b = lvl;
            end
            2: begin
                ro_a = ((ph_a % per_a) < (per_a / 2));
                ro_b = ro_a;
            end
            default: begin
                ro_a = (since_start >= 2);
                ro_b = ro_a;
            end
        endcase
    end

    // A level sampled at edge k produces a pulse counted at edge k+2.
    function automatic int edge_count(input bit chan);
        int c = 0;
        for (int k = t + S + 1; k <= t + S + G; k++) begin
            if (k >= 3 && k < HLEN) begin
                if (chan == 1'b0 && xa[k-2] && !xa[k-3]) c++;
                if (chan == 1'b1 && xb[k-2] && !xb[k-3]) c++;
            end
        end
        return c;
    endfunction

    always @(posedge CLK) begin
        int ra;
        int rb;
        n = n + 1;
        if (n < HLEN) begin
            xa[n] = ro_a;
            xb[n] = ro_b;
        end
        if (rst) begin
            active  = 1'b0;
            m_valid = 1'b0;
            m_a8 = '0; m_b8 = '0; m_a4 = '0; m_b4 = '0;
            m_resp8 = 1'b0; m_tie8 = 1'b0; m_sat8 = 1'b0;
            m_resp4 = 1'b0; m_tie4 = 1'b0; m_sat4 = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (active) begin
                if (n == t + S + G) begin
                    ra      = edge_count(1'b0);
                    rb      = edge_count(1'b1);
                    m_a8    = 8'((ra > 255) ? 255 : ra);
                    m_b8    = 8'((rb > 255) ? 255 : rb);
                    m_a4    = 4'((ra > 15) ? 15 : ra);
                    m_b4    = 4'((rb > 15) ? 15 : rb);
                    m_resp8 = (m_a8 > m_b8);
                    m_tie8  = (m_a8 == m_b8);
                    m_sat8  = (ra >= 255) || (rb >= 255);
                    m_resp4 = (m_a4 > m_b4);
                    m_tie4  = (m_a4 == m_b4);
                    m_sat4  = (ra >= 15) || (rb >= 15);
                    m_valid = 1'b1;
                end
                if (n == t + S + G + 1) active = 1'b0;
            end else if (start) begin
                active = 1'b1;
                t      = n;
            end
        end
        m_busy  = active;
        m_ro_en = active && (n < t + S + G);
    end

    always @(negedge CLK) begin
        logic [21:0] got8, exp8;
        logic [13:0] got4, exp4;
        if (chk_en) begin
            got8 = {ro_en8, busy8, valid8, count_a8, count_b8, resp8, tie8, sat8};
            exp8 = {m_ro_en, m_busy, m_valid, m_a8, m_b8, m_resp8, m_tie8, m_sat8};
            got4 = {ro_en4, busy4, valid4, count_a4, count_b4, resp4, tie4, sat4};
            exp4 = {m_ro_en, m_busy, m_valid, m_a4, m_b4, m_resp4, m_tie4, m_sat4};
            vectors = vectors + 2;
            if (got8 !== exp8) begin
                miscompares++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("[TB] FAIL model_cw8 edge %0d: got %h expected %h", n, got8, exp8);
                end
            end
            if (got4 !== exp4) begin
                miscompares++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("[TB] FAIL model_cw4 edge %0d: got %h expected %h", n, got4, exp4);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Sets up the sources, pulses start once and waits (bounded) for valid.
    task automatic applyStimulus(input int mode, input int pa, input int pb,
                                 input bit level, output int lat);
        gen_mode = mode;
        per_a    = pa;
        per_b    = pb;
        lvl      = level;
        ph_a     = $urandom_range(0, 99);
        ph_b     = $urandom_range(0, 99);
        repeat (6) @(negedge CLK);
        start       = 1'b1;
        since_start = 0;
        @(negedge CLK);
        start = 1'b0;
        lat   = 1;
        while (!valid8 && lat < 400) begin
            @(negedge CLK);
            lat++;
        end
        if (!valid8) begin
            miscompares++;
            $display("[TB] FAIL valid_timeout: got no valid after %0d cycles expected 105", lat);
        end
    endtask

    initial begin
        repeat (9000) @(posedge CLK);
        miscompares++;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int  lat;
        bit  seen;
        rst   = 1'b1;
        start = 1'b0;
        ro_a  = 1'b0;
        ro_b  = 1'b0;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        checkOutput("reset_busy", busy8, 0);
        checkOutput("reset_ro_en", ro_en8, 0);
        checkOutput("reset_count_a", count_a8, 0);
        rst = 1'b0;

        applyStimulus(0, 10, 8, 1'b0, lat);
        checkOutput("p10p8_latency", lat, 105);
        checkOutput("p10p8_count_a", count_a8, 10);
        checkOutput("p10p8_count_b_12_13", (count_b8 == 8'd12 || count_b8 == 8'd13), 1);
        checkOutput("p10p8_resp", resp8, 0);
        checkOutput("p10p8_tie", tie8, 0);
        checkOutput("p10p8_sat", sat8, 0);
        checkOutput("p10p8_model_a", m_a8, 10);

        applyStimulus(2, 10, 10, 1'b0, lat);
        checkOutput("same_src_count_a", count_a8, 10);
        checkOutput("same_src_count_b", count_b8, 10);
        checkOutput("same_src_tie", tie8, 1);
        checkOutput("same_src_resp", resp8, 0);

        applyStimulus(0, 4, 10, 1'b0, lat);
        checkOutput("sat_cw4_count_a", count_a4, 15);
        checkOutput("sat_cw4_sat", sat4, 1);
        checkOutput("sat_cw4_resp", resp4, 1);
        checkOutput("sat_cw8_count_a", count_a8, 25);
        checkOutput("sat_cw8_sat", sat8, 0);

        // Abort mid-gate: outputs return to reset values and no valid appears.
        gen_mode = 0; per_a = 6; per_b = 7;
        repeat (6) @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (50) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        checkOutput("abort_busy", busy8, 0);
        checkOutput("abort_ro_en", ro_en8, 0);
        checkOutput("abort_count_a", count_a8, 0);
        checkOutput("abort_sat4", sat4, 0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            if (valid8 || valid4) seen = 1'b1;
        end
        checkOutput("abort_no_valid", seen, 0);
        applyStimulus(0, 10, 8, 1'b0, lat);
        checkOutput("after_abort_latency", lat, 105);
        checkOutput("after_abort_count_a", count_a8, 10);

        // start re-asserted during SETTLE and GATE must be ignored.
        repeat (6) @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        lat   = 1;
        while (!valid8 && lat < 400) begin
            @(negedge CLK);
            lat++;
            if (!valid8) start = (lat == 2 || lat == 50);
            if (lat == 50) checkOutput("retrigger_hold_count_a", count_a8, 10);
        end
        start = 1'b0;
        checkOutput("retrigger_latency", lat, 105);
        checkOutput("retrigger_count_a", count_a8, 10);

        applyStimulus(1, 10, 10, 1'b1, lat);
        checkOutput("const1_count_a", count_a8, 0);
        checkOutput("const1_tie", tie8, 1);
        applyStimulus(1, 10, 10, 1'b0, lat);
        checkOutput("const0_count_b", count_b8, 0);
        checkOutput("const0_tie", tie8, 1);
        applyStimulus(3, 10, 10, 1'b0, lat);
        checkOutput("settle_edge_count_a", count_a8, 0);
        checkOutput("settle_edge_resp", resp8, 0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(($urandom_range(0, 4) == 0) ? 2 : 0,
                          $urandom_range(4, 24), $urandom_range(4, 24), 1'b0, lat);
            checkOutput("rand_latency", lat, 105);
        end

        repeat (5) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ro_pair_meter.md
# ro_pair_meter

Synchronous ring-oscillator pair measurement unit for the PUF datapath. On a `start` request it enables two external ring oscillators, waits a settle interval, and counts rising edges of each oscillator in the `CLK` domain over a fixed gate window. It then reports both counts, a one-bit PUF response (`count_a > count_b`), and tie and saturation flags. It is the CLK-domain reader of the oscillator outputs and replaces free-running, oscillator-clocked counters feeding the seven-segment display path.

## Interface
Parameters:
- `CW`, 16, width of each edge counter and count output.
- `SETTLE_CYC`, 1000, CLK cycles the oscillators run before counting starts (≥1).
- `GATE_CYC`, 100000, CLK cycles of the counting window (≥1).

Ports:
- `CLK` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: measurement request, sampled only in IDLE.
- `ro_a` in 1: oscillator A output, asynchronous, pre-divided so its frequency is < CLK/4.
- `ro_b` in 1: oscillator B output, same constraints as `ro_a`.
- `ro_en` out 1: oscillator enable, drives both oscillators.
- `busy` out 1: high in every state except IDLE.
- `valid` out 1: one-cycle pulse when results update.
- `count_a` out CW: edge count of A from the last measurement.
- `count_b` out CW: edge count of B from the last measurement.
- `resp` out 1: 1 iff `count_a > count_b`.
- `tie` out 1: 1 iff `count_a == count_b`.
- `sat` out 1: 1 if either counter saturated during the last measurement.

## Operation
- Each oscillator input passes through a 2-FF synchronizer, then a third register for rising-edge detection. The edge pulse is `s2 & ~s3`.
- FSM states and transitions:
  - IDLE to SETTLE on `start`. The settle counter clears and both edge counters clear.
  - SETTLE holds `ro_en=1` for SETTLE_CYC cycles, then goes to GATE. Edges seen in SETTLE are ignored.
  - GATE holds `ro_en=1` for exactly GATE_CYC cycles. Each counter increments on every cycle its edge pulse is high. After the last GATE cycle, go to DONE.
  - DONE (1 cycle) drops `ro_en`, latches `count_a`, `count_b`, `resp`, `tie`, `sat` into output registers, pulses `valid`, then returns to IDLE.
- Counters saturate at 2^CW−1; no wrap. The saturation flag is sticky until the next start.
- Comparison is unsigned on saturated values. Ties give `resp=0` and `tie=1`.
- The output registers hold their last result until the next DONE. They are not cleared at start.
- `start` outside IDLE is ignored; no queuing.
- Reset in any state returns to IDLE on the next edge. The measurement is aborted and `valid` is not produced.
- Reset values: `ro_en=0`, `busy=0`, `valid=0`, `count_a=0`, `count_b=0`, `resp=0`, `tie=0`, `sat=0`, all internal counters 0, synchronizer flops 0.

## Timing
- `start` high at edge t: SETTLE occupies edges t+1 … t+SETTLE_CYC.
- GATE occupies the next GATE_CYC edges.
- DONE and `valid` fall at t+SETTLE_CYC+GATE_CYC+1.
- `busy` and `ro_en` rise at t+1. `ro_en` falls entering DONE; `busy` falls entering IDLE.
- Back-to-back measurements: the earliest next accepted `start` is the cycle after DONE.
- Input-to-edge-pulse latency is 3 CLK cycles. An edge arriving within the last 2 cycles of GATE is not counted. This is accepted: both channels see identical latency.
- Results are stable from the DONE edge onward. `valid` is registered and coincides with the output update.

## Structure
- Shared package `puf_pkg`:
  - FSM state enum `meter_state_t` (IDLE, SETTLE, GATE, DONE).
  - Default-parameter constants reused by the top-level.
- Sub-module `edge_sync`: 2-FF synchronizer plus rising-edge detector, ports `CLK`, `rst`, `d`, `rise`. It is instantiated twice.
- Settle/gate timer: a single down-counter of width `$clog2(max(SETTLE_CYC,GATE_CYC)+1)`, reloaded per state.

## Test plan
Common parameters: CW=8, SETTLE_CYC=4, GATE_CYC=100.
- `ro_a` square wave period 10 CLK, `ro_b` period 8 CLK, `start` pulse: expected `count_a=10`, `count_b` 12 or 13, `resp=0`, `tie=0`, `sat=0`, `valid` exactly 105 cycles after `start`.
- Both inputs driven from the same period-10 source: expected `count_a=count_b=10`, `tie=1`, `resp=0`.
- CW=4 with `ro_a` period 4 (25 edges): expected `count_a=15`, `sat=1`; with `ro_b` period 10, `resp=1`.
- Reset mid-GATE:
  - Expect `ro_en=0` and `busy=0` the next cycle, no `valid` pulse, and outputs at reset values.
  - A subsequent `start` completes normally.
- `start` re-asserted during SETTLE and during GATE: expect no restart and `valid` timing unchanged; outputs hold the previous result until DONE.
- Inputs held constant at 1 and at 0: expect `count_a=count_b=0`, `tie=1`, and edges during SETTLE not counted.
